// File: rtl/drawing_engine.sv
// drawing_engine: raster rectangle walker that feeds the VGA adapter's pixel-write port.
// Modes: solid fill, streamed 1-bit bitmap (optional transparency), full-screen clear.
// Geometry is latched on start; pixels outside the screen are walked but never plotted.
module drawing_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int SZ_W     = 8,
  parameter int COLOR_W  = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               transparent,
  input  logic [X_W-1:0]     x0,
  input  logic [Y_W-1:0]     y0,
  input  logic [SZ_W-1:0]    width,
  input  logic [SZ_W-1:0]    height,
  input  logic [COLOR_W-1:0] fg_color,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic               busy,
  output logic               done,
  output logic               plot,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] color
);

  localparam logic [1:0] MODE_BITMAP = 2'b01;
  localparam logic [1:0] MODE_CLEAR  = 2'b10;

  // Screen bounds at the width of the clipping sums
  localparam logic [X_W:0] SCR_W = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0] SCR_H = (Y_W+1)'(SCREEN_H);

  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;

  // Everything the draw needs, captured at start. Clear mode is folded into a
  // solid draw of the whole screen in bg_color, so only the bitmap flag survives.
  typedef struct packed {
    logic               bitmap;
    logic               transp;
    logic [X_W-1:0]     ox;
    logic [Y_W-1:0]     oy;
    logic [SZ_W-1:0]    w;
    logic [SZ_W-1:0]    h;
    logic [COLOR_W-1:0] fg;
    logic [COLOR_W-1:0] bg;
  } req_t;

  state_t          state;
  req_t            req, nreq;
  logic [SZ_W-1:0] cx, cy;

  logic [X_W:0]       xs;
  logic [Y_W:0]       ys;
  logic               empty, last_col, last_row, adv, vis, pix_on;
  logic [COLOR_W-1:0] pix_col;

  // Request decode: mode 11 falls through as solid, clear overrides geometry and colour
  always_comb begin
    nreq        = '0;
    nreq.bitmap = (mode == MODE_BITMAP);
    nreq.transp = transparent;
    if (mode == MODE_CLEAR) begin
      nreq.ox = '0;
      nreq.oy = '0;
      nreq.w  = SZ_W'(SCREEN_W);
      nreq.h  = SZ_W'(SCREEN_H);
      nreq.fg = bg_color;
      nreq.bg = bg_color;
    end else begin
      nreq.ox = x0;
      nreq.oy = y0;
      nreq.w  = width;
      nreq.h  = height;
      nreq.fg = fg_color;
      nreq.bg = bg_color;
    end
  end

  // Pixel datapath: one-bit-wider sums so off-screen coordinates clip instead of wrapping
  always_comb begin
    xs       = (X_W+1)'(req.ox) + (X_W+1)'(cx);
    ys       = (Y_W+1)'(req.oy) + (Y_W+1)'(cy);
    empty    = (req.w == '0) || (req.h == '0);
    last_col = (cx == req.w - SZ_W'(1));
    last_row = (cy == req.h - SZ_W'(1));
    adv      = (state == DRAW) && !empty && (!req.bitmap || bit_valid);
    vis      = (xs < SCR_W) && (ys < SCR_H);
    pix_on   = vis && !(req.bitmap && req.transp && !bit_in);
    pix_col  = (req.bitmap && !bit_in) ? req.bg : req.fg;
  end

  assign bit_ready = (state == DRAW) && req.bitmap;

  // Control FSM with registered pixel outputs; outputs hold across stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      req   <= '0;
      cx    <= '0;
      cy    <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      plot  <= 1'b0;
      x     <= '0;
      y     <= '0;
      color <= '0;
    end else begin
      done <= 1'b0;
      plot <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            req   <= nreq;
            cx    <= '0;
            cy    <= '0;
            busy  <= 1'b1;
            state <= DRAW;
          end
        end
        DRAW: begin
          if (empty) begin
            // nothing to walk: finish at once and pulse done on entering FIN
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else if (adv) begin
            plot  <= pix_on;
            x     <= xs[X_W-1:0];
            y     <= ys[Y_W-1:0];
            color <= pix_col;
            if (last_col) begin
              cx <= '0;
              cy <= cy + SZ_W'(1);
              if (last_row) begin
                state <= FIN;
                busy  <= 1'b0;
              end
            end else begin
              cx <= cx + SZ_W'(1);
            end
          end
        end
        FIN: begin
          state <= IDLE;
          done  <= !empty;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_drawing_engine.sv
// tb_drawing_engine: directed + randomized draws checked cycle by cycle against
// a pixel-list reference model built from the rectangle/clip/colour rules.
module tb_drawing_engine;
  localparam int SW = 160;
  localparam int SH = 120;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0, transparent = 1'b0;
  logic       bit_in = 1'b0, bit_valid = 1'b0;
  logic [1:0] mode = '0;
  logic [7:0] x0 = '0;
  logic [6:0] y0 = '0;
  logic [7:0] width = '0, height = '0;
  logic [2:0] fg_color = '0, bg_color = '0;
  logic       bit_ready, busy, done, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] color;

  int n_cmp = 0;
  int n_err = 0;
  int ex = 0, ey = 0, ec = 0;   // last presented pixel (outputs hold between advances)
  bit bq[$];                    // forced bitmap bits for the next draw
  bit vq[$];                    // forced bit_valid pattern for the next draw

  always #5 clk = ~clk;

  drawing_engine dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .transparent(transparent),
    .x0(x0), .y0(y0), .width(width), .height(height), .fg_color(fg_color), .bg_color(bg_color),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready), .busy(busy), .done(done),
    .plot(plot), .x(x), .y(y), .color(color)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Latched inputs must be ignored after start, so churn them during draws
  task automatic scramble();
    mode        = 2'($urandom);
    transparent = 1'($urandom);
    x0          = 8'($urandom);
    y0          = 7'($urandom);
    width       = 8'($urandom);
    height      = 8'($urandom);
    fg_color    = 3'($urandom);
    bg_color    = 3'($urandom);
  endtask

  // One draw from start to done; called at a negedge, returns at a negedge.
  task automatic run(input logic [1:0] m, input bit tr, input int ox, input int oy,
                     input int w, input int h, input int fg, input int bg,
                     input bit poke, input string tag);
    int bx, by, bw, bh, bfg, bbg, n, idx, fin, dcyc, c, px, py, pc, gx, gy;
    bit bm, pend, pon, adv, v;
    bit bits[$];
    bm = (m == 2'b01);
    if (m == 2'b10) begin
      bx = 0; by = 0; bw = SW; bh = SH; bfg = bg; bbg = bg;
    end else begin
      bx = ox; by = oy; bw = w; bh = h; bfg = fg; bbg = bg;
    end
    n = bw * bh;
    for (int k = 0; k < n; k++) bits.push_back((bq.size() > 0) ? bq.pop_front() : 1'($urandom));
    mode = m; transparent = tr; x0 = 8'(ox); y0 = 7'(oy); width = 8'(w); height = 8'(h);
    fg_color = 3'(fg); bg_color = 3'(bg); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    fin  = (n == 0) ? 1 : -1;
    dcyc = (n == 0) ? 1 : -1;
    idx = 0; pend = 0; pon = 0; px = 0; py = 0; pc = 0;
    for (c = 0; c < n * 8 + 20; c++) begin
      if (pend) begin ex = px; ey = py; ec = pc; end
      chk({tag, " plot"},      32'(plot),      32'(pend && pon));
      chk({tag, " x"},         32'(x),         ex);
      chk({tag, " y"},         32'(y),         ey);
      chk({tag, " color"},     32'(color),     ec);
      chk({tag, " busy"},      32'(busy),      32'(fin < 0 || c < fin));
      chk({tag, " bit_ready"}, 32'(bit_ready), 32'(bm && (fin < 0 || c < fin)));
      chk({tag, " done"},      32'(done),      32'(c == dcyc));
      if (c == dcyc) break;
      pend = 0;
      bit_in = 1'($urandom);
      bit_valid = 1'($urandom);
      start = poke && (c == n / 2 || c == fin);
      scramble();
      if (fin < 0) begin
        adv = 1;
        if (bm) begin
          v = (vq.size() > 0) ? vq.pop_front() : ($urandom_range(0, 3) != 0);
          bit_valid = v;
          bit_in = bits[idx];
          adv = v;
        end
        if (adv) begin
          gx = bx + idx % bw;
          gy = by + idx / bw;
          px = gx % 256;
          py = gy % 128;
          pc = (bm && !bits[idx]) ? bbg : bfg;
          pon = (gx < SW) && (gy < SH) && !(bm && tr && !bits[idx]);
          pend = 1;
          idx++;
          if (idx == n) begin fin = c + 1; dcyc = c + 2; end
        end
      end
      @(negedge clk);
    end
    chk({tag, " done reached"}, c, dcyc);
    start = 1'b0; bit_valid = 1'b0;
    @(negedge clk);
    chk({tag, " busy after done"}, 32'(busy), 0);
    chk({tag, " done width"},      32'(done), 0);
    chk({tag, " idle plot"},       32'(plot), 0);
    bq.delete(); vq.delete();
  endtask

  initial begin
    // reset values
    #2 reset = 1'b0;
    #1;
    chk("rst plot", 32'(plot), 0);
    chk("rst x", 32'(x), 0);
    chk("rst y", 32'(y), 0);
    chk("rst color", 32'(color), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst bit_ready", 32'(bit_ready), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    run(2'b00, 1'b0, 10, 5, 3, 2, 5, 1, 1'b0, "solid");
    bq = '{1, 0, 1, 1};
    vq = '{1, 1, 0, 0, 1, 1};
    run(2'b01, 1'b1, 20, 30, 4, 1, 6, 3, 1'b0, "bitmap");
    run(2'b00, 1'b0, 158, 119, 4, 2, 7, 0, 1'b0, "clip");
    run(2'b10, 1'b0, 77, 33, 9, 9, 5, 2, 1'b0, "clear");
    run(2'b00, 1'b0, 5, 5, 0, 7, 3, 3, 1'b1, "empty_w");
    run(2'b01, 1'b0, 5, 5, 7, 0, 3, 3, 1'b1, "empty_h");
    run(2'b00, 1'b0, 30, 40, 5, 4, 4, 1, 1'b1, "poke");
    run(2'b11, 1'b0, 150, 100, 12, 3, 6, 2, 1'b0, "mode3");

    // abort a 10x10 draw after three pixels
    mode = 2'b00; x0 = 8'd0; y0 = 7'd0; width = 8'd10; height = 8'd10; fg_color = 3'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort pre plot", 32'(plot), 1);
    chk("abort pre x", 32'(x), 2);
    reset = 1'b0;
    #1;
    chk("abort plot", 32'(plot), 0);
    chk("abort x", 32'(x), 0);
    chk("abort y", 32'(y), 0);
    chk("abort color", 32'(color), 0);
    chk("abort busy", 32'(busy), 0);
    chk("abort bit_ready", 32'(bit_ready), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("abort no done", 32'(done), 0);
    end
    reset = 1'b1;
    ex = 0; ey = 0; ec = 0;
    @(negedge clk);
    chk("post abort done", 32'(done), 0);
    chk("post abort busy", 32'(busy), 0);

    for (int i = 0; i < 20; i++) begin
      logic [1:0] m;
      m = 2'($urandom_range(0, 3));
      if (m == 2'b10) m = 2'b01;
      run(m, 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 127),
          $urandom_range(0, 20), $urandom_range(0, 10), $urandom_range(0, 7),
          $urandom_range(0, 7), 1'($urandom), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/drawing_engine.md
# drawing_engine

Parametrised raster drawing engine feeding the VGA adapter's pixel-write port. It is the successor to the fixed-size sprite drawer. Given an origin and a rectangle size, it walks the rectangle in raster order and emits one pixel write per accepted pixel. It supports three modes (solid fill, streamed 1-bit bitmap with optional transparency, full-screen clear), clips against the screen edge and signals completion with a start/busy/done handshake.

## Interface

Parameters:
- X_W, 8, width of x coordinate
- Y_W, 7, width of y coordinate
- SZ_W, 8, width of width/height inputs
- COLOR_W, 3, pixel colour width
- SCREEN_W, 160, visible columns
- SCREEN_H, 120, visible rows

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  request a draw; sampled only in IDLE
- mode  in  2  00 solid, 01 bitmap, 10 clear, 11 treated as solid
- transparent  in  1  bitmap mode only: a 0 bit produces no write
- x0  in  X_W  rectangle origin column
- y0  in  Y_W  rectangle origin row
- width  in  SZ_W  rectangle columns; 0 means an empty draw
- height  in  SZ_W  rectangle rows; 0 means an empty draw
- fg_color  in  COLOR_W  colour for solid pixels and bitmap 1s
- bg_color  in  COLOR_W  colour for bitmap 0s and clear mode
- bit_in  in  1  bitmap pixel bit, raster order
- bit_valid  in  1  bit_in is valid
- bit_ready  out  1  engine accepts a bit this cycle
- busy  out  1  draw in progress
- done  out  1  one-cycle completion pulse
- plot  out  1  pixel write strobe to the VGA adapter
- x  out  X_W  pixel column
- y  out  Y_W  pixel row
- color  out  COLOR_W  pixel colour

## Operation

- FSM states: IDLE, DRAW, FIN.
  - IDLE goes to DRAW on start=1.
  - DRAW goes to FIN after the last pixel advances, or immediately if width=0 or height=0.
  - FIN goes to IDLE unconditionally.
- On start, all inputs are latched except bit_in and bit_valid. Later input changes have no effect until the next start.
- Clear mode overrides the geometry to origin (0,0), size SCREEN_W x SCREEN_H and colour bg_color.
- Column counter cx runs 0..w-1. When cx reaches w-1 it wraps to 0 and row counter cy increments. The last pixel is cx=w-1, cy=h-1.
- A pixel advances every DRAW cycle in solid and clear modes.
- In bitmap mode a pixel advances only on cycles with bit_valid && bit_ready.
  - bit_ready = (state==DRAW && mode==bitmap).
  - On a stall, counters hold and plot=0.
- Pixel colour:
  - solid: fg_color
  - bitmap: bit_in ? fg_color : bg_color
  - clear: bg_color
- Transparency: in bitmap mode with transparent=1, a 0 bit advances the counters with plot=0.
- Clipping: the sums x0+cx and y0+cy are computed one bit wider than X_W/Y_W. If the column sum is >= SCREEN_W or the row sum is >= SCREEN_H, plot=0 but the counters still advance. x and y output the truncated low bits.
- start while busy=1 is ignored. start in the FIN cycle is also ignored.

## Timing

- Reset values: plot=0, x=0, y=0, color=0, busy=0, done=0, bit_ready=0, state IDLE, counters 0.
- Asserting reset mid-draw aborts at once to the reset values. No done pulse is produced.
- x, y, color and plot are registered. Each pixel advance at edge Ek produces that pixel's outputs in the cycle following Ek.
- Let E0 be the edge at which start is accepted. busy=1 from E0 until the edge that enters FIN.
- Solid/clear latency: pixel k (k=0..w*h-1) is presented after edge E(k+1). done=1 for exactly one cycle, after edge E(w*h+1), with busy=0 in that cycle.
- Empty draw (width or height 0): done pulses after E1, with no plot.
- A new start is accepted in the cycle after done, at the earliest.
- Throughput: one pixel per clock when not stalled.

## Test plan

- Solid draw, w=3, h=2, origin (10,5), fg_color=5 -> plot for 6 consecutive cycles at (10,5),(11,5),(12,5),(10,6),(11,6),(12,6), colour 5; done one cycle later; busy high for exactly 6 cycles.
- Bitmap draw, w=4, h=1, origin (20,30), transparent=1, bits 1,0,1,1, bit_valid low for 2 cycles between bits 2 and 3 -> plots at x=20,22,23 only; no plot and outputs held during the stall; bit_ready low after done.
- Clipping, solid w=4, h=2 at (158,119) -> only (158,119) and (159,119) plotted; done after 8 pixel cycles plus 1.
- Clear mode, bg_color=2 -> 19200 consecutive plots; first (0,0), last (159,119), all colour 2; done follows.
- Empty draw with width=0 -> no plot; done high one cycle after start; busy never observed high in the cycle after done.
- Reset asserted after 3 pixels of a 10x10 draw -> all outputs 0 immediately, no done. A start pulsed mid-draw in a separate run is ignored: pixel count is unchanged and there is a single done.
